// File: rtl/mult_accum_if.sv
// Product-in / group-sum-out handshake bundle for mult_accum.
interface mult_accum_if #(
  parameter int PW = 8,
  parameter int AW = 10
);
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_p;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic          out_ovf;

  modport master (
    output in_valid, in_p, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_p, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/mult_accum.sv
// Sums each group of COUNT products into a one-entry output register;
// the next group accumulates while the previous result is still pending.
module mult_accum #(
  parameter int PW    = 8,
  parameter int AW    = 10,
  parameter int COUNT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  mult_accum_if.slave bus
);
  localparam int CW = (COUNT > 2) ? $clog2(COUNT) : 1;

  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          ovf_acc;
  logic [AW-1:0] sum_q;
  logic          ovf_q;
  logic          valid_q;

  logic [AW:0]   sum_ext;
  logic          carry;
  logic          last;
  logic          ready;
  logic          in_fire;
  logic          out_fire;

  assign sum_ext  = {1'b0, acc} + {{(AW + 1 - PW){1'b0}}, bus.in_p};
  assign carry    = sum_ext[AW];
  assign last     = (cnt == CW'(COUNT - 1));
  // Stall only when the final beat would overwrite a result that is not draining.
  assign ready    = !clr && !(last && valid_q && !bus.out_ready);
  assign in_fire  = bus.in_valid && ready;
  assign out_fire = valid_q && bus.out_ready;

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_ovf   = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
    end else if (clr) begin
      acc     <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
    end else if (in_fire) begin
      if (last) begin
        acc     <= '0;
        cnt     <= '0;
        ovf_acc <= 1'b0;
      end else begin
        acc     <= sum_ext[AW-1:0];
        cnt     <= cnt + 1'b1;
        ovf_acc <= ovf_acc | carry;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (in_fire && last) begin
      sum_q   <= sum_ext[AW-1:0];
      ovf_q   <= ovf_acc | carry;
      valid_q <= 1'b1;
    end else if (out_fire) begin
      valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mult_accum.sv
// Directed and random checks of mult_accum against a group-sum reference model.
module tb_mult_accum;
  localparam int PW    = 8;
  localparam int AW    = 10;
  localparam int COUNT = 8;

  typedef struct {
    int unsigned sum;
    bit          ovf;
  } res_t;

  logic clk;
  logic rst_n;
  logic clr;

  mult_accum_if #(.PW(PW), .AW(AW)) bus ();

  mult_accum #(.PW(PW), .AW(AW), .COUNT(COUNT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp;
  int unsigned n_err;
  int unsigned grp[$];
  res_t        res_q[$];
  int unsigned obs_sum;
  bit          obs_ovf;
  bit          obs_valid;
  bit          obs_rdy;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: a completed group is just the plain integer sum of its products.
  function automatic res_t group_result();
    int unsigned total;
    res_t r;
    total = 0;
    foreach (grp[i]) total += grp[i];
    r.sum = total % (1 << AW);
    r.ovf = (total >= (1 << AW));
    return r;
  endfunction

  task automatic step(input bit v, input int unsigned p, input bit ordy, input bit c);
    bit exp_rdy;
    bit in_f;
    bit out_f;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_p      = p[PW-1:0];
    bus.out_ready = ordy;
    clr           = c;
    #1;
    exp_rdy = !c && !(grp.size() == COUNT - 1 && res_q.size() > 0 && !ordy);
    obs_sum   = bus.out_sum;
    obs_ovf   = bus.out_ovf;
    obs_valid = bus.out_valid;
    obs_rdy   = bus.in_ready;
    check("in_ready", obs_rdy, exp_rdy);
    check("out_valid", obs_valid, res_q.size() > 0);
    if (res_q.size() > 0) begin
      check("out_sum", obs_sum, res_q[0].sum);
      check("out_ovf", obs_ovf, res_q[0].ovf);
    end
    in_f  = v && exp_rdy;
    out_f = (res_q.size() > 0) && ordy;
    @(posedge clk);
    if (c) grp.delete();
    if (out_f) void'(res_q.pop_front());
    if (in_f) begin
      grp.push_back(p);
      if (grp.size() == COUNT) begin
        res_q.push_back(group_result());
        grp.delete();
      end
    end
  endtask

  task automatic beats(input int n, input int unsigned p, input bit ordy);
    for (int i = 0; i < n; i++) step(1'b1, p, ordy, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    clr   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_p      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_sum", bus.out_sum, 0);
    check("rst_ovf", bus.out_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain group of ones
    beats(COUNT, 1, 1'b1);
    step(1'b0, 0, 1'b1, 1'b0);
    check("t1_valid", obs_valid, 1);
    check("t1_sum", obs_sum, 8);
    check("t1_ovf", obs_ovf, 0);

    // Overflowing group, then sticky flag must clear
    beats(COUNT, 225, 1'b1);
    step(1'b0, 0, 1'b1, 1'b0);
    check("t2_sum", obs_sum, 776);
    check("t2_ovf", obs_ovf, 1);
    beats(COUNT, 1, 1'b1);
    step(1'b0, 0, 1'b1, 1'b0);
    check("t2b_sum", obs_sum, 8);
    check("t2b_ovf", obs_ovf, 0);

    // Back-pressure across two groups
    beats(COUNT, 10, 1'b0);
    beats(COUNT - 1, 20, 1'b0);
    step(1'b1, 20, 1'b0, 1'b0);
    check("t3_stall", obs_rdy, 0);
    check("t3_held", obs_sum, 80);
    step(1'b1, 20, 1'b0, 1'b0);
    check("t3_stall2", obs_rdy, 0);
    step(1'b1, 20, 1'b1, 1'b0);
    check("t3_go", obs_rdy, 1);
    step(1'b0, 0, 1'b0, 1'b0);
    check("t3_valid", obs_valid, 1);
    check("t3_sumB", obs_sum, 160);
    step(1'b0, 0, 1'b1, 1'b0);

    // clr discards a partial group but not a pending result
    beats(COUNT, 5, 1'b0);
    beats(3, 100, 1'b0);
    step(1'b1, 100, 1'b0, 1'b1);
    check("t4_clr_rdy", obs_rdy, 0);
    step(1'b0, 0, 1'b0, 1'b0);
    check("t4_pend_valid", obs_valid, 1);
    check("t4_pend_sum", obs_sum, 40);
    beats(COUNT, 2, 1'b1);
    step(1'b0, 0, 1'b1, 1'b0);
    check("t4_sum", obs_sum, 16);

    // Asynchronous reset between edges with a held result
    beats(COUNT, 7, 1'b0);
    beats(5, 9, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_valid", bus.out_valid, 0);
    check("t5_sum", bus.out_sum, 0);
    grp.delete();
    res_q.delete();
    #1;
    rst_n = 1'b1;
    beats(COUNT, 3, 1'b1);
    step(1'b0, 0, 1'b1, 1'b0);
    check("t5_sum24", obs_sum, 24);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 255),
           $urandom_range(0, 2) != 0, $urandom_range(0, 60) == 0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 1'b0);
    check("drained", res_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
